// File: rtl/cmd_pkg.sv
// Shared types and constants for the cmd_parser command decoder.
package cmd_pkg;

    localparam int unsigned DIG_W      = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned TMO_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGITS  = 2'd1,
        ST_WAIT_CR = 2'd2
    } state_e;

    // Slot 0 = minute tens, 1 = minute ones, 2 = second tens, 3 = second ones.
    typedef logic [NUM_DIGITS-1:0][DIG_W-1:0] digits_t;

    localparam logic [7:0] ASCII_CR   = 8'h0d;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_L_LO = 8'h6c;
    localparam logic [7:0] ASCII_L_UP = 8'h4c;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_A_UP = 8'h41;

    localparam logic [DIG_W-1:0] LIM_TENS = 4'd5;
    localparam logic [DIG_W-1:0] LIM_ONES = 4'd9;

    function automatic logic is_alarm_byte(input logic [7:0] b);
        return (b == ASCII_A_LO) || (b == ASCII_A_UP);
    endfunction

    function automatic logic is_cmd_byte(input logic [7:0] b);
        return (b == ASCII_L_LO) || (b == ASCII_L_UP) || is_alarm_byte(b);
    endfunction

endpackage

// File: rtl/ascii_digit_chk.sv
// Combinational ASCII-to-BCD conversion with digit and range qualification.
module ascii_digit_chk
    import cmd_pkg::*;
(
    input  logic [7:0]       ascii_i,
    input  logic [DIG_W-1:0] limit_i,
    output logic [DIG_W-1:0] bcd_c,
    output logic             is_digit_c,
    output logic             in_range_c
);

    always_comb begin
        bcd_c      = DIG_W'(ascii_i - ASCII_0);
        is_digit_c = (ascii_i >= ASCII_0) && (ascii_i <= ASCII_9);
        in_range_c = is_digit_c && (bcd_c <= limit_i);
    end

endmodule

// File: rtl/cmd_parser.sv
// Parses "l"/"a" + four BCD digits + CR into time/alarm loads with idle timeout.
// Defining CMD_PARSER_ECHO_EN echoes every received byte on tx_data one cycle later.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter logic [7:0]       CR_CODE     = ASCII_CR,
    parameter logic [TMO_W-1:0] TIMEOUT_CYC = 16'd24000
) (
    input  logic             clk12m,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_rdy,
    output logic             ld_time,
    output logic             ld_alarm,
    output logic [DIG_W-1:0] dig_mt,
    output logic [DIG_W-1:0] dig_mo,
    output logic [DIG_W-1:0] dig_st,
    output logic [DIG_W-1:0] dig_so,
    output logic             cmd_err,
    output logic [7:0]       tx_data,
    output logic             tx_data_rdy
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             alarm_q, alarm_d;
    digits_t          shadow_q, shadow_d;
    digits_t          dig_q, dig_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ld_time_q, ld_time_d;
    logic             ld_alarm_q, ld_alarm_d;
    logic             cmd_err_q, cmd_err_d;

    logic [DIG_W-1:0] bcd_c;
    logic             is_digit_c;
    logic             in_range_c;
    logic [DIG_W-1:0] limit_c;

    // Tens slots (even index) allow 0-5, ones slots allow 0-9.
    assign limit_c = idx_q[0] ? LIM_ONES : LIM_TENS;

    ascii_digit_chk u_digit_chk (
        .ascii_i    (rx_data),
        .limit_i    (limit_c),
        .bcd_c      (bcd_c),
        .is_digit_c (is_digit_c),
        .in_range_c (in_range_c)
    );

    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            alarm_q    <= 1'b0;
            shadow_q   <= '0;
            dig_q      <= '0;
            tmo_q      <= '0;
            ld_time_q  <= 1'b0;
            ld_alarm_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            alarm_q    <= alarm_d;
            shadow_q   <= shadow_d;
            dig_q      <= dig_d;
            tmo_q      <= tmo_d;
            ld_time_q  <= ld_time_d;
            ld_alarm_q <= ld_alarm_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        alarm_d    = alarm_q;
        shadow_d   = shadow_q;
        dig_d      = dig_q;
        tmo_d      = tmo_q;
        ld_time_d  = 1'b0;
        ld_alarm_d = 1'b0;
        cmd_err_d  = 1'b0;

        if (rx_data_rdy) begin
            // A received byte always reloads the timeout, even on the expiry cycle.
            tmo_d = '0;
            if (is_cmd_byte(rx_data)) begin
                state_d = ST_DIGITS;
                alarm_d = is_alarm_byte(rx_data);
                idx_d   = '0;
            end else begin
                unique case (state_q)
                    ST_DIGITS: begin
                        if (in_range_c) begin
                            shadow_d[idx_q] = bcd_c;
                            idx_d           = idx_q + IDX_W'(1);
                            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                                state_d = ST_WAIT_CR;
                            end
                        end else begin
                            cmd_err_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                    ST_WAIT_CR: begin
                        if (rx_data == CR_CODE) begin
                            dig_d      = shadow_q;
                            ld_time_d  = ~alarm_q;
                            ld_alarm_d = alarm_q;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TIMEOUT_CYC - TMO_W'(1)) begin
                cmd_err_d = 1'b1;
                state_d   = ST_IDLE;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign ld_time  = ld_time_q;
    assign ld_alarm = ld_alarm_q;
    assign cmd_err  = cmd_err_q;
    assign dig_mt   = dig_q[0];
    assign dig_mo   = dig_q[1];
    assign dig_st   = dig_q[2];
    assign dig_so   = dig_q[3];

`ifdef CMD_PARSER_ECHO_EN
    logic [7:0] tx_data_q;
    logic       tx_rdy_q;

    always_ff @(posedge clk12m or posedge rst) begin
        if (rst) begin
            tx_data_q <= '0;
            tx_rdy_q  <= 1'b0;
        end else begin
            tx_rdy_q <= rx_data_rdy;
            if (rx_data_rdy) begin
                tx_data_q <= rx_data;
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_data_rdy = tx_rdy_q;
`else
    assign tx_data     = '0;
    assign tx_data_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: rule-level command model, directed cases plus random bytes.
module tb_cmd_parser;

    localparam int          T    = 40;
    localparam logic [7:0]  CR   = 8'h0d;
    localparam int          K_TIME  = 0;
    localparam int          K_ALARM = 1;
    localparam int          K_ERR   = 2;

    logic       clk12m = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       ld_time, ld_alarm, cmd_err, tx_data_rdy;
    logic [3:0] dig_mt, dig_mo, dig_st, dig_so;
    logic [7:0] tx_data;

    cmd_parser #(.CR_CODE(CR), .TIMEOUT_CYC(16'(T))) dut (
        .clk12m      (clk12m),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .ld_time     (ld_time),
        .ld_alarm    (ld_alarm),
        .dig_mt      (dig_mt),
        .dig_mo      (dig_mo),
        .dig_st      (dig_st),
        .dig_so      (dig_so),
        .cmd_err     (cmd_err),
        .tx_data     (tx_data),
        .tx_data_rdy (tx_data_rdy)
    );

    initial forever #5 clk12m = ~clk12m;

    int cyc = 0;
    always @(posedge clk12m) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] edge_n;
        logic [15:0] digs;
    } ev_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] edge_n;
    } echo_t;

    ev_t   evq[$];
    echo_t echoq[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model state: command in progress, collected digits, displayed digits.
    bit          act = 0;
    bit          m_alarm = 0;
    int          n = 0;
    int          last = 0;
    logic [3:0]  sh [4];
    logic [15:0] mdig = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int e);
        ev_t ev;
        ev.kind   = 2'(kind);
        ev.edge_n = 32'(e);
        ev.digs   = mdig;
        evq.push_back(ev);
    endtask

    // Fire an idle timeout if the command in progress has been quiet too long before edge e.
    task automatic model_advance(input int e);
        if (act && (e - last > T)) begin
            push_ev(K_ERR, last + T);
            act = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int e);
        bit   letter;
        bit   alarm_b;
        int   lim;
        echo_t ec;
        ec.data   = b;
        ec.edge_n = 32'(e);
        echoq.push_back(ec);
        alarm_b = (b == 8'h61) || (b == 8'h41);
        letter  = alarm_b || (b == 8'h6c) || (b == 8'h4c);
        if (letter) begin
            act = 1; m_alarm = alarm_b; n = 0; last = e;
            return;
        end
        if (!act) return;
        last = e;
        if (n < 4) begin
            lim = (n % 2 == 0) ? 5 : 9;
            if (b >= 8'h30 && b <= 8'h39 && int'(b) - 48 <= lim) begin
                sh[n] = 4'(int'(b) - 48);
                n++;
            end else begin
                push_ev(K_ERR, e);
                act = 0;
            end
        end else if (b == CR) begin
            mdig = {sh[0], sh[1], sh[2], sh[3]};
            push_ev(m_alarm ? K_ALARM : K_TIME, e);
            act = 0;
        end else begin
            push_ev(K_ERR, e);
            act = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk12m);
        model_advance(cyc + 1);
        model_byte(b, cyc + 1);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        @(posedge clk12m);
        #1 rx_data_rdy = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk12m);
            model_advance(cyc + 1);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_digs(input string name);
        @(negedge clk12m);
        model_advance(cyc + 1);
        #1 chk(name, 32'({dig_mt, dig_mo, dig_st, dig_so}), 32'(mdig));
    endtask

    task automatic do_reset();
        @(negedge clk12m);
        model_advance(cyc + 1);
        #2 rst = 1'b1;
        act = 0;
        mdig = '0;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        #1;
        chk("rst_digs", 32'({dig_mt, dig_mo, dig_st, dig_so}), 32'h0);
        chk("rst_pulses", 32'({ld_time, ld_alarm, cmd_err, tx_data_rdy}), 32'h0);
        @(negedge clk12m);
        #2 rst = 1'b0;
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        logic [7:0] letters [4];
        letters[0] = 8'h6c; letters[1] = 8'h4c; letters[2] = 8'h61; letters[3] = 8'h41;
        r = $urandom_range(0, 99);
        if (r < 12)      return letters[$urandom_range(0, 3)];
        else if (r < 75) return 8'(8'h30 + $urandom_range(0, 9));
        else if (r < 88) return CR;
        else             return 8'($urandom_range(0, 255));
    endfunction

    // Monitor: pops an expected event whenever the DUT pulses and compares it.
    initial forever begin
        int   pulses;
        ev_t  ev;
        echo_t ec;
        logic [1:0] got_kind;
        @(negedge clk12m);
        #1;
        pulses = int'(ld_time) + int'(ld_alarm) + int'(cmd_err);
        if (pulses != 0) begin
            chk("pulse_exclusive", 32'(pulses), 32'd1);
            got_kind = ld_time ? 2'(K_TIME) : (ld_alarm ? 2'(K_ALARM) : 2'(K_ERR));
            if (evq.size() == 0) begin
                chk("unexpected_pulse_kind", 32'(got_kind), 32'hffff_ffff);
            end else begin
                ev = evq.pop_front();
                chk("event_kind", 32'(got_kind), 32'(ev.kind));
                chk("event_cycle", 32'(cyc), ev.edge_n);
                chk("event_digs", 32'({dig_mt, dig_mo, dig_st, dig_so}), 32'(ev.digs));
            end
        end
`ifdef CMD_PARSER_ECHO_EN
        if (tx_data_rdy) begin
            if (echoq.size() == 0) begin
                chk("unexpected_echo", 32'(tx_data), 32'hffff_ffff);
            end else begin
                ec = echoq.pop_front();
                chk("echo_data", 32'(tx_data), 32'(ec.data));
                chk("echo_cycle", 32'(cyc), ec.edge_n);
            end
        end
`else
        echoq.delete();
        chk("echo_tied_off", 32'({tx_data_rdy, tx_data}), 32'h0);
`endif
    end

    initial begin
        for (int i = 0; i < 4; i++) sh[i] = '0;
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b0;
        repeat (3) @(negedge clk12m);
        #1;
        chk("init_digs", 32'({dig_mt, dig_mo, dig_st, dig_so}), 32'h0);
        chk("init_pulses", 32'({ld_time, ld_alarm, cmd_err}), 32'h0);
        chk("init_tx", 32'({tx_data_rdy, tx_data}), 32'h0);
        #1 rst = 1'b0;

        // Time load, then alarm load with time digits held in between.
        send_str("l5955"); send_byte(CR);
        check_digs("digs_after_time");
        idle(5);
        check_digs("digs_held");
        send_str("a0324"); send_byte(CR);
        check_digs("digs_after_alarm");

        // Out-of-range tens digit, trailing bytes ignored in idle.
        send_str("l7000"); send_byte(CR);
        check_digs("digs_after_reject");

        // Restart mid-command switches to alarm.
        send_str("l12a0001"); send_byte(CR);
        check_digs("digs_after_restart");

        // Idle timeout, then stray bytes in idle.
        send_str("l12");
        idle(T + 3);
        send_str("5"); send_byte(CR);

        // Byte arriving on the expiry cycle wins.
        send_str("l1");
        idle(T - 1);
        send_str("2");
        idle(T - 1);
        send_str("34"); send_byte(CR);
        check_digs("digs_boundary");

        // CR too early, and a non-CR in the terminator slot.
        send_str("a12"); send_byte(CR);
        send_str("a1234x");
        send_str("L5959"); send_byte(CR);
        send_str("A0000"); send_byte(CR);

        // Reset mid-command discards the partial command.
        send_str("l59");
        do_reset();
        send_str("55"); send_byte(CR);
        idle(T + 3);
        check_digs("digs_after_reset");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 24) == 0) idle($urandom_range(T - 2, T + 2));
                else if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
                send_byte(pick_byte());
            end
        end

        idle(T + 5);
        check_digs("digs_final");
        chk("events_outstanding", 32'(evq.size()), 32'd0);
        chk("echo_outstanding", 32'(echoq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
